wide_add_seq: RTL and testbench

Byte-serial wide adder that accepts two WORDS×8-bit operands over a valid/ready handshake and adds them one byte per clock through a single instance of the existing 8-bit carry-lookahead slice (`adder8`). The block sits directly upstream of the slice: it feeds `A`, `B` and `cin` to the slice and consumes its `sum` and `cout`. A registered carry is kept between byte steps. It gives datapaths wide add results at the area cost of one slice, in exchange for WORDS cycles of latency.

---
 rtl/wide_add_pkg.sv | 20 ++
 rtl/adder8.sv | 33 +++
 rtl/wide_add_seq.sv | 131 +++++++++++++
 tb/tb_wide_add_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the byte-serial wide adder.
//   state_e   : controller states (IDLE, RUN, DONE)
//   BYTE_W    : width of one serial step / slice
//   idx_width : width of the byte index for a given operand byte count
package wide_add_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte index width; kept at least 1 so WORDS=1 still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/adder8.sv
// 8-bit carry-lookahead adder slice.
//   A, B : byte operands
//   cin  : carry in
//   sum  : A+B+cin modulo 256
//   cout : carry out of bit 7
module adder8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Carry recurrence; unrolled into lookahead terms by synthesis.
  always_comb begin
    carry    = 9'd0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum  = prop ^ carry[7:0];
  assign cout = carry[8];

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial wide adder: adds two WORDS-byte operands one byte per clock
// through a single adder8 slice, keeping the carry in a register between
// steps. Valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin  : operands and carry into byte 0
//   in_sub              : subtract select (only with WIDE_ADD_SUB_EN)
//   out_valid/out_ready : result handshake, result held until accepted
//   out_sum, out_cout   : result and carry out of the top byte
// Optional feature macro: WIDE_ADD_SUB_EN (adds in_sub, A-B-cin).
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*WORDS-1:0] in_a,
  input  logic [BYTE_W*WORDS-1:0] in_b,
  input  logic                    in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                    in_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*WORDS-1:0] out_sum,
  output logic                    out_cout
);

  localparam int unsigned W     = BYTE_W * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);

  state_e             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       res_q;
  logic [W-1:0]       res_d;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       out_sum_q;
  logic               out_cout_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               sub_c;
  logic [BYTE_W-1:0]  slice_sum;
  logic               slice_cout;
  logic               last_c;

`ifdef WIDE_ADD_SUB_EN
  assign sub_c = in_sub;
`else
  assign sub_c = 1'b0;
`endif

  // Slice sees only register outputs, so the critical path is one byte add.
  adder8 u_slice (
    .A    (a_q[BYTE_W-1:0]),
    .B    (b_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result shifts right with the new byte entering at the top; the
  // concatenate-then-shift form also covers WORDS=1.
  assign res_d  = W'({slice_sum, res_q} >> BYTE_W);
  assign last_c = (idx_q == IDX_W'(WORDS - 1));

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + !cin, i.e. A - B - cin.
            a_q        <= in_a;
            b_q        <= in_b ^ {W{sub_c}};
            carry_q    <= in_cin ^ sub_c;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          res_q   <= res_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_c) begin
            out_sum_q   <= res_d;
            out_cout_q  <= slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with WORDS=4.
module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef WIDE_ADD_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, check latency and result, then accept the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef WIDE_ADD_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract requested without WIDE_ADD_SUB_EN");
`endif
    in_valid = 1'b1;
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(WORDS));
    check_eq({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    check_eq({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_back_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cyc[$];
    int res_q[$];
    int cyc;
    int i;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_sum", 64'(out_sum), 64'd0);
    check_eq("rst_out_cout", 64'(out_cout), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    run_op("full_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    run_op("mixed",      32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
    run_op("top_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

    // Backpressure: result held, new operands offered but not taken.
    in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < int'(WORDS); k++) tick();
    check_eq("bp_valid", 64'(out_valid), 64'd1);
    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_sum_hold", 64'(out_sum), 64'h30);
      check_eq("bp_cout_hold", 64'(out_cout), 64'd0);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    check_eq("bp_sum_after", 64'(out_sum), 64'h30);

    // Reset two cycles after acceptance.
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_valid", 64'(out_valid), 64'd0);
    check_eq("midrun_rst_sum", 64'(out_sum), 64'd0);
    check_eq("midrun_rst_cout", 64'(out_cout), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", 64'(in_ready), 64'd1);
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    run_op("post_rst_add", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0);

    // Streaming with both handshakes held high.
    i = 1;
    in_a = W'(i); in_b = W'(i); in_cin = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (res_q.size() < 4 && cyc < 100) begin
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        i++;
        if (i > 4) in_valid = 1'b0;
        in_a = W'(i); in_b = W'(i);
      end
      if (out_valid) res_q.push_back(int'(out_sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("stream_count", 64'(res_q.size()), 64'd4);
    check_eq("stream_accepts", 64'(acc_cyc.size()), 64'd4);
    for (int k = 0; k < res_q.size(); k++)
      check_eq($sformatf("stream_res%0d", k), 64'(res_q[k]), 64'(2 * (k + 1)));
    for (int k = 1; k < acc_cyc.size(); k++)
      check_eq($sformatf("stream_ii%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd6);
    tick();
    tick();

`ifdef WIDE_ADD_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    run_op("sub_off", 32'd7, 32'd5, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
